// File: rtl/mos_sweep_seq.sv
// Bias-sweep sequencer: steps gate/drain DAC codes per enabled channel, settles, measures, streams results.
// Latency: dac_load one cycle after start; per point 1 + settle + meas(>=1) + emit(>=1) + 1 cycles.
// Backpressure: waits in MEAS for meas_ack and holds res_valid/payload in EMIT until res_ready.
module mos_sweep_seq #(
    parameter int NCH  = 4,
    parameter int VG_W = 8,
    parameter int VD_W = 8,
    parameter int DW   = 12,
    parameter int SW   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cfg_mode,
    input  logic [NCH-1:0]          cfg_ch_mask,
    input  logic [VG_W-1:0]         cfg_vg_start,
    input  logic [VG_W-1:0]         cfg_vg_stop,
    input  logic [VG_W-1:0]         cfg_vg_step,
    input  logic [VD_W-1:0]         cfg_vd_start,
    input  logic [VD_W-1:0]         cfg_vd_stop,
    input  logic [VD_W-1:0]         cfg_vd_step,
    input  logic [SW-1:0]           cfg_settle,
    output logic [NCH-1:0]          ch_sel,
    output logic [VG_W-1:0]         vg_code,
    output logic [VD_W-1:0]         vd_code,
    output logic                    dac_load,
    output logic                    meas_req,
    input  logic                    meas_ack,
    input  logic [DW-1:0]           meas_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(NCH)-1:0]  res_ch,
    output logic [VG_W-1:0]         res_vg,
    output logic [VD_W-1:0]         res_vd,
    output logic [DW-1:0]           res_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int CW = $clog2(NCH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_MEAS   = 3'd3;
    localparam logic [2:0] S_EMIT   = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;

    localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

    logic [2:0]      state;
    logic            mode_q;
    logic [NCH-1:0]  mask_q;
    logic [VG_W-1:0] vg_start_q, vg_stop_q, vg_step_q;
    logic [VD_W-1:0] vd_start_q, vd_stop_q, vd_step_q;
    logic [SW-1:0]   settle_q, settle_cnt;
    logic [CW-1:0]   ch_idx;

    logic            first_found, nxt_found;
    logic [CW-1:0]   first_idx, nxt_idx;
    logic [VG_W:0]   vg_sum;
    logic [VD_W:0]   vd_sum;
    logic            vg_adv, vd_adv, inner_adv, outer_adv, cfg_err;

    assign dac_load  = (state == S_LOAD);
    assign meas_req  = (state == S_MEAS);
    assign res_valid = (state == S_EMIT);
    assign busy      = (state != S_IDLE);

    // Lowest enabled channel of the incoming mask, and next enabled channel above the current one
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        nxt_found   = 1'b0;
        nxt_idx     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cfg_ch_mask[i]) begin
                first_found = 1'b1;
                first_idx   = CW'(i);
            end
            if (mask_q[i] && (i > int'(ch_idx))) begin
                nxt_found = 1'b1;
                nxt_idx   = CW'(i);
            end
        end
    end

    // Axis advance uses one extra bit so a sum past the code range counts as beyond stop
    assign vg_sum    = {1'b0, vg_code} + {1'b0, vg_step_q};
    assign vd_sum    = {1'b0, vd_code} + {1'b0, vd_step_q};
    assign vg_adv    = (vg_step_q != '0) && (vg_sum <= {1'b0, vg_stop_q});
    assign vd_adv    = (vd_step_q != '0) && (vd_sum <= {1'b0, vd_stop_q});
    assign inner_adv = mode_q ? vd_adv : vg_adv;
    assign outer_adv = mode_q ? vg_adv : vd_adv;
    assign cfg_err   = (cfg_vg_start > cfg_vg_stop) || (cfg_vd_start > cfg_vd_stop);

    // Sweep state machine with registered DAC codes, channel select and result payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            mask_q     <= '0;
            vg_start_q <= '0;
            vg_stop_q  <= '0;
            vg_step_q  <= '0;
            vd_start_q <= '0;
            vd_stop_q  <= '0;
            vd_step_q  <= '0;
            settle_q   <= '0;
            settle_cnt <= '0;
            ch_idx     <= '0;
            ch_sel     <= '0;
            vg_code    <= '0;
            vd_code    <= '0;
            res_ch     <= '0;
            res_vg     <= '0;
            res_vd     <= '0;
            res_data   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                state      <= S_IDLE;
                settle_cnt <= '0;
                ch_idx     <= '0;
                ch_sel     <= '0;
                vg_code    <= '0;
                vd_code    <= '0;
                res_ch     <= '0;
                res_vg     <= '0;
                res_vd     <= '0;
                res_data   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            mode_q     <= cfg_mode;
                            mask_q     <= cfg_ch_mask;
                            vg_start_q <= cfg_vg_start;
                            vg_stop_q  <= cfg_vg_stop;
                            vg_step_q  <= cfg_vg_step;
                            vd_start_q <= cfg_vd_start;
                            vd_stop_q  <= cfg_vd_stop;
                            vd_step_q  <= cfg_vd_step;
                            settle_q   <= cfg_settle;
                            err        <= cfg_err;
                            if (cfg_err || !first_found) begin
                                done <= 1'b1;
                            end else begin
                                state   <= S_LOAD;
                                ch_idx  <= first_idx;
                                ch_sel  <= ONE_HOT0 << first_idx;
                                vg_code <= cfg_vg_start;
                                vd_code <= cfg_vd_start;
                            end
                        end
                    end
                    S_LOAD: begin
                        settle_cnt <= '0;
                        state      <= (settle_q == '0) ? S_MEAS : S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == settle_q - 1'b1) begin
                            state <= S_MEAS;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_MEAS: begin
                        if (meas_ack) begin
                            res_data <= meas_data;
                            res_ch   <= ch_idx;
                            res_vg   <= vg_code;
                            res_vd   <= vd_code;
                            state    <= S_EMIT;
                        end
                    end
                    S_EMIT: begin
                        if (res_ready) begin
                            state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        state <= S_LOAD;
                        if (inner_adv) begin
                            if (mode_q) vd_code <= vd_sum[VD_W-1:0];
                            else        vg_code <= vg_sum[VG_W-1:0];
                        end else if (outer_adv) begin
                            if (mode_q) begin
                                vd_code <= vd_start_q;
                                vg_code <= vg_sum[VG_W-1:0];
                            end else begin
                                vg_code <= vg_start_q;
                                vd_code <= vd_sum[VD_W-1:0];
                            end
                        end else if (nxt_found) begin
                            ch_idx  <= nxt_idx;
                            ch_sel  <= ONE_HOT0 << nxt_idx;
                            vg_code <= vg_start_q;
                            vd_code <= vd_start_q;
                        end else begin
                            state   <= S_IDLE;
                            done    <= 1'b1;
                            ch_idx  <= '0;
                            ch_sel  <= '0;
                            vg_code <= '0;
                            vd_code <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mos_sweep_seq.sv
// Self-checking bench for mos_sweep_seq: directed scenarios plus randomized sweeps vs. a nested-loop model.
// Latency: checks start-to-dac_load, per-point spacing, done pulse timing.
// Backpressure: drives delayed meas_ack and stalled res_ready, checks held requests and stable payloads.
module tb_mos_sweep_seq;

    localparam int NCH     = 4;
    localparam int CYC_MAX = 30000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, cfg_mode = 1'b0;
    logic [3:0]  cfg_ch_mask = '0;
    logic [7:0]  cfg_vg_start = '0, cfg_vg_stop = '0, cfg_vg_step = '0;
    logic [7:0]  cfg_vd_start = '0, cfg_vd_stop = '0, cfg_vd_step = '0;
    logic [15:0] cfg_settle = '0;
    logic [3:0]  ch_sel;
    logic [7:0]  vg_code, vd_code;
    logic        dac_load, meas_req;
    logic        meas_ack = 1'b0;
    logic [11:0] meas_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [1:0]  res_ch;
    logic [7:0]  res_vg, res_vd;
    logic [11:0] res_data;
    logic        busy, done, err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int ch;
        int vg;
        int vd;
    } pt_t;
    pt_t exp_q[$];
    bit  exp_err;

    mos_sweep_seq #(.NCH(NCH), .VG_W(8), .VD_W(8), .DW(12), .SW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_ch_mask(cfg_ch_mask),
        .cfg_vg_start(cfg_vg_start), .cfg_vg_stop(cfg_vg_stop), .cfg_vg_step(cfg_vg_step),
        .cfg_vd_start(cfg_vd_start), .cfg_vd_stop(cfg_vd_stop), .cfg_vd_step(cfg_vd_step),
        .cfg_settle(cfg_settle), .ch_sel(ch_sel), .vg_code(vg_code), .vd_code(vd_code),
        .dac_load(dac_load), .meas_req(meas_req), .meas_ack(meas_ack), .meas_data(meas_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_vg(res_vg),
        .res_vd(res_vd), .res_data(res_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected point list straight from the sweep rules, using plain integer loops
    task automatic build_model();
        int os, oe, ostp, is, ie, istp;
        exp_q.delete();
        exp_err = (cfg_vg_start > cfg_vg_stop) || (cfg_vd_start > cfg_vd_stop);
        if (exp_err) return;
        if (cfg_mode) begin
            os = cfg_vg_start; oe = cfg_vg_stop; ostp = cfg_vg_step;
            is = cfg_vd_start; ie = cfg_vd_stop; istp = cfg_vd_step;
        end else begin
            os = cfg_vd_start; oe = cfg_vd_stop; ostp = cfg_vd_step;
            is = cfg_vg_start; ie = cfg_vg_stop; istp = cfg_vg_step;
        end
        for (int c = 0; c < NCH; c++) begin
            if (!cfg_ch_mask[c]) continue;
            for (int o = os; o <= oe; o += ostp) begin
                for (int i = is; i <= ie; i += istp) begin
                    pt_t p;
                    p.ch = c;
                    p.vg = cfg_mode ? o : i;
                    p.vd = cfg_mode ? i : o;
                    exp_q.push_back(p);
                    if (istp == 0) break;
                end
                if (ostp == 0) break;
            end
        end
    endtask

    task automatic do_start();
        build_model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycle-by-cycle responder and scoreboard; entered at the negedge just after start was sampled
    task automatic run_sweep(input int ack_fix, input int rdy_fix, input int ack_max,
                             input int rdy_max, input int gap_exp);
        int load_idx, res_idx, req_cnt, req_tgt, val_cnt, val_tgt, cyc, last_acc;
        logic [11:0] data_q[$];
        logic [29:0] held;
        logic [3:0]  oh;
        bit fin;
        load_idx = 0; res_idx = 0; req_cnt = 0; req_tgt = 0;
        val_cnt = 0; val_tgt = 0; cyc = 0; last_acc = -1; fin = 0; held = '0;
        while (!fin) begin
            if (cyc == 0) chk("start_to_load", {31'd0, dac_load}, {31'd0, exp_q.size() > 0});
            if (dac_load) begin
                if (load_idx < exp_q.size()) begin
                    oh = 4'b0001 << exp_q[load_idx].ch;
                    chk("load_ch_sel", {28'd0, ch_sel}, {28'd0, oh});
                    chk("load_vg", {24'd0, vg_code}, exp_q[load_idx].vg);
                    chk("load_vd", {24'd0, vd_code}, exp_q[load_idx].vd);
                end else begin
                    chk("extra_load", 32'd1, 32'd0);
                end
                load_idx++;
            end
            meas_ack = 1'b0;
            if (meas_req) begin
                if (req_cnt == 0) req_tgt = (ack_fix > 0) ? ack_fix : $urandom_range(1, ack_max);
                req_cnt++;
                if (req_cnt == req_tgt) begin
                    meas_ack  = 1'b1;
                    meas_data = 12'($urandom);
                    data_q.push_back(meas_data);
                end
            end else if (req_cnt != 0) begin
                chk("meas_req_len", req_cnt, req_tgt);
                req_cnt = 0;
            end
            res_ready = 1'b0;
            if (res_valid) begin
                if (val_cnt == 0) begin
                    val_tgt = (rdy_fix > 0) ? rdy_fix : $urandom_range(1, rdy_max);
                    held = {res_ch, res_vg, res_vd, res_data};
                    if (res_idx < exp_q.size() && data_q.size() > 0) begin
                        chk("res_ch", {30'd0, res_ch}, exp_q[res_idx].ch);
                        chk("res_vg", {24'd0, res_vg}, exp_q[res_idx].vg);
                        chk("res_vd", {24'd0, res_vd}, exp_q[res_idx].vd);
                        chk("res_data", {20'd0, res_data}, {20'd0, data_q.pop_front()});
                    end else begin
                        chk("extra_result", 32'd1, 32'd0);
                    end
                end else begin
                    chk("payload_stable", {2'd0, res_ch, res_vg, res_vd, res_data}, {2'd0, held});
                end
                val_cnt++;
                if (val_cnt == val_tgt) begin
                    res_ready = 1'b1;
                    if (gap_exp > 0 && last_acc >= 0) chk("point_gap", cyc - last_acc, gap_exp);
                    last_acc = cyc;
                    res_idx++;
                end
            end else if (val_cnt != 0) begin
                chk("res_valid_len", val_cnt, val_tgt);
                val_cnt = 0;
            end
            if (done) begin
                fin = 1;
                chk("done_busy_low", {31'd0, busy}, 32'd0);
                chk("result_count", res_idx, exp_q.size());
                chk("load_count", load_idx, exp_q.size());
                chk("err_flag", {31'd0, err}, {31'd0, exp_err});
            end else if (cyc >= CYC_MAX) begin
                fin = 1;
                chk("sweep_timeout", 32'd0, 32'd1);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        meas_ack  = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic set_cfg(input logic mode, input logic [3:0] mask,
                           input logic [7:0] gs, input logic [7:0] ge, input logic [7:0] gp,
                           input logic [7:0] ds, input logic [7:0] de, input logic [7:0] dp,
                           input logic [15:0] st);
        cfg_mode = mode; cfg_ch_mask = mask;
        cfg_vg_start = gs; cfg_vg_stop = ge; cfg_vg_step = gp;
        cfg_vd_start = ds; cfg_vd_stop = de; cfg_vd_step = dp;
        cfg_settle = st;
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ch_sel", {28'd0, ch_sel}, 32'd0);
        chk("rst_codes", {16'd0, vg_code, vd_code}, 32'd0);
        chk("rst_strobes", {28'd0, dac_load, meas_req, res_valid, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Id-Vg sweep, two channels, immediate handshakes, 7-cycle spacing
        set_cfg(1'b0, 4'b0101, 8'd10, 8'd30, 8'd10, 8'd50, 8'd50, 8'd0, 16'd3);
        do_start();
        chk("model_pts_idvg", exp_q.size(), 6);
        run_sweep(1, 1, 1, 1, 7);

        // Id-Vd sweep near code top: 250, 254 only
        set_cfg(1'b1, 4'b0001, 8'd5, 8'd5, 8'd0, 8'd250, 8'd255, 8'd4, 16'd0);
        do_start();
        chk("model_pts_sat", exp_q.size(), 2);
        run_sweep(1, 1, 1, 1, 0);

        // Handshake stalls: meas_req held 5 cycles, res_valid held 5 cycles
        set_cfg(1'b0, 4'b0010, 8'd0, 8'd2, 8'd1, 8'd7, 8'd9, 8'd2, 16'd1);
        do_start();
        run_sweep(5, 5, 1, 1, 0);

        // Config error
        set_cfg(1'b0, 4'b1111, 8'd40, 8'd20, 8'd1, 8'd0, 8'd0, 8'd0, 16'd2);
        do_start();
        chk("cfg_err_no_points", exp_q.size(), 0);
        run_sweep(1, 1, 1, 1, 0);

        // Empty channel mask: done, no points, err cleared
        set_cfg(1'b0, 4'b0000, 8'd0, 8'd3, 8'd1, 8'd0, 8'd0, 8'd0, 16'd0);
        do_start();
        run_sweep(1, 1, 1, 1, 0);

        // Abort in SETTLE, then full restart
        set_cfg(1'b1, 4'b1000, 8'd3, 8'd6, 8'd3, 8'd1, 8'd2, 8'd1, 16'd5);
        do_start();
        chk("abort_pre_load", {31'd0, dac_load}, 32'd1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ch_sel", {28'd0, ch_sel}, 32'd0);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        chk("abort_codes", {16'd0, vg_code, vd_code}, 32'd0);
        chk("abort_err", {31'd0, err}, 32'd0);
        do_start();
        run_sweep(0, 0, 2, 2, 0);

        // Async reset while in MEAS
        set_cfg(1'b0, 4'b0011, 8'd1, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0, 16'd2);
        do_start();
        n = 0;
        while (!meas_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_meas", {31'd0, meas_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_meas_req", {31'd0, meas_req}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ch_sel", {28'd0, ch_sel}, 32'd0);
        chk("arst_codes", {16'd0, vg_code, vd_code}, 32'd0);
        chk("arst_flags", {29'd0, res_valid, done, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_no_done", {31'd0, done}, 32'd0);

        // Randomized sweeps against the model
        for (int k = 0; k < 6; k++) begin
            logic [7:0] gs, ge, gp, ds, de, dp;
            gs = 8'($urandom_range(0, 255));
            ge = 8'((int'(gs) + $urandom_range(0, 120) > 255) ? 255 : int'(gs) + $urandom_range(0, 120));
            gp = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(20, 60));
            ds = 8'($urandom_range(0, 255));
            de = 8'((int'(ds) + $urandom_range(0, 120) > 255) ? 255 : int'(ds) + $urandom_range(0, 120));
            dp = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(20, 60));
            if ($urandom_range(0, 7) == 0 && gs != ge) begin
                logic [7:0] t;
                t = gs; gs = ge; ge = t;
            end
            set_cfg(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    gs, ge, gp, ds, de, dp, 16'($urandom_range(0, 3)));
            do_start();
            run_sweep(0, 0, 3, 3, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
